morse_encoder: RTL

Morse transmitter: the send-side counterpart of the button-driven Morse decoder. Accepts ASCII characters over a valid/ready handshake, looks up each character's dot/dash pattern and drives a single key line (LED/buzzer) with mark and space durations chosen to land inside the decoder's classification windows. A keyed output fed back into the decoder's button input reproduces the original text.

---
 rtl/morse_encoder_if.sv | 19 +
 rtl/morse_encoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/morse_encoder_if.sv
// Character handshake between a text source and the Morse encoder.
// The master drives characters; the slave (encoder) answers with ready.
interface morse_encoder_if;
    logic [7:0] char_i;
    logic       char_valid_i;
    logic       char_ready_o;

    modport master (
        output char_i,
        output char_valid_i,
        input  char_ready_o
    );

    modport slave (
        input  char_i,
        input  char_valid_i,
        output char_ready_o
    );
endinterface

// File: rtl/morse_encoder.sv
// Morse transmitter: turns ASCII characters into timed marks and spaces on a
// single key line, with durations chosen to fall inside the decoder's windows.
module morse_encoder #(
    parameter int unsigned DOT_TICKS        = 15_000_000,
    parameter int unsigned DASH_TICKS       = 60_000_000,
    parameter int unsigned ELEM_GAP_TICKS   = 50_000_000,
    parameter int unsigned LETTER_GAP_TICKS = 200_000_000,
    parameter int unsigned WORD_GAP_TICKS   = 300_000_000
) (
    input  logic              clk,
    input  logic              rst,
    morse_encoder_if.slave    char_if,
    output logic              key_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_MARK       = 3'd1;
    localparam logic [2:0] S_ELEM_GAP   = 3'd2;
    localparam logic [2:0] S_LETTER_GAP = 3'd3;
    localparam logic [2:0] S_WORD_GAP   = 3'd4;

    localparam logic [31:0] DOT_M1    = 32'(DOT_TICKS - 1);
    localparam logic [31:0] DASH_M1   = 32'(DASH_TICKS - 1);
    localparam logic [31:0] EGAP_M1   = 32'(ELEM_GAP_TICKS - 1);
    localparam logic [31:0] LGAP_M1   = 32'(LETTER_GAP_TICKS - 1);
    localparam logic [31:0] WGAP_M1   = 32'(WORD_GAP_TICKS - 1);

    generate
        if (DOT_TICKS < 1 || ELEM_GAP_TICKS < 1 ||
            DOT_TICKS >= DASH_TICKS ||
            ELEM_GAP_TICKS >= LETTER_GAP_TICKS ||
            LETTER_GAP_TICKS >= WORD_GAP_TICKS) begin : g_bad_timing
            $error("morse_encoder: timing parameters must be >= 1 with DOT < DASH and ELEM_GAP < LETTER_GAP < WORD_GAP");
        end
    endgenerate

    logic [2:0]  r_state;
    logic [31:0] r_cnt;
    logic [2:0]  r_elems;
    logic [4:0]  r_shift;
    logic        r_key;
    logic        r_busy;
    logic        r_err;

    logic [7:0]  w_upper;
    logic [2:0]  w_len;
    logic [4:0]  w_pat;
    logic        w_space;
    logic        w_xfer;
    logic        w_cnt_done;

    // NOTE: ready decodes the state directly, so a valid held by the source is taken on the first IDLE cycle.
    assign char_if.char_ready_o = (r_state == S_IDLE);
    assign w_xfer     = char_if.char_valid_i && char_if.char_ready_o;
    assign w_cnt_done = (r_cnt == 32'd0);
    assign w_space    = (char_if.char_i == 8'h20);

    // Code ROM: length plus a left-aligned pattern sent bit 4 first, 1 = dash.
    always_comb begin
        w_upper = char_if.char_i;
        if (char_if.char_i >= 8'h61 && char_if.char_i <= 8'h7A) begin
            w_upper = char_if.char_i - 8'h20;
        end
        w_len = 3'd0;
        w_pat = 5'b00000;
        case (w_upper)
            "A": {w_len, w_pat} = {3'd2, 5'b01000};
            "B": {w_len, w_pat} = {3'd4, 5'b10000};
            "C": {w_len, w_pat} = {3'd4, 5'b10100};
            "D": {w_len, w_pat} = {3'd3, 5'b10000};
            "E": {w_len, w_pat} = {3'd1, 5'b00000};
            "F": {w_len, w_pat} = {3'd4, 5'b00100};
            "G": {w_len, w_pat} = {3'd3, 5'b11000};
            "H": {w_len, w_pat} = {3'd4, 5'b00000};
            "I": {w_len, w_pat} = {3'd2, 5'b00000};
            "J": {w_len, w_pat} = {3'd4, 5'b01110};
            "K": {w_len, w_pat} = {3'd3, 5'b10100};
            "L": {w_len, w_pat} = {3'd4, 5'b01000};
            "M": {w_len, w_pat} = {3'd2, 5'b11000};
            "N": {w_len, w_pat} = {3'd2, 5'b10000};
            "O": {w_len, w_pat} = {3'd3, 5'b11100};
            "P": {w_len, w_pat} = {3'd4, 5'b01100};
            "Q": {w_len, w_pat} = {3'd4, 5'b11010};
            "R": {w_len, w_pat} = {3'd3, 5'b01000};
            "S": {w_len, w_pat} = {3'd3, 5'b00000};
            "T": {w_len, w_pat} = {3'd1, 5'b10000};
            "U": {w_len, w_pat} = {3'd3, 5'b00100};
            "V": {w_len, w_pat} = {3'd4, 5'b00010};
            "W": {w_len, w_pat} = {3'd3, 5'b01100};
            "X": {w_len, w_pat} = {3'd4, 5'b10010};
            "Y": {w_len, w_pat} = {3'd4, 5'b10110};
            "Z": {w_len, w_pat} = {3'd4, 5'b11000};
            "0": {w_len, w_pat} = {3'd5, 5'b11111};
            "1": {w_len, w_pat} = {3'd5, 5'b01111};
            "2": {w_len, w_pat} = {3'd5, 5'b00111};
            "3": {w_len, w_pat} = {3'd5, 5'b00011};
            "4": {w_len, w_pat} = {3'd5, 5'b00001};
            "5": {w_len, w_pat} = {3'd5, 5'b00000};
            "6": {w_len, w_pat} = {3'd5, 5'b10000};
            "7": {w_len, w_pat} = {3'd5, 5'b11000};
            "8": {w_len, w_pat} = {3'd5, 5'b11100};
            "9": {w_len, w_pat} = {3'd5, 5'b11110};
            default: {w_len, w_pat} = {3'd0, 5'b00000};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 32'd0;
            r_elems <= 3'd0;
            r_shift <= 5'd0;
            r_key   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        if (w_len != 3'd0) begin
                            r_state <= S_MARK;
                            r_cnt   <= w_pat[4] ? DASH_M1 : DOT_M1;
                            r_shift <= {w_pat[3:0], 1'b0};
                            r_elems <= w_len - 3'd1;
                            r_key   <= 1'b1;
                            r_busy  <= 1'b1;
                        end else if (w_space) begin
                            r_state <= S_WORD_GAP;
                            r_cnt   <= WGAP_M1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_MARK: begin
                    if (w_cnt_done) begin
                        r_key <= 1'b0;
                        if (r_elems != 3'd0) begin
                            r_state <= S_ELEM_GAP;
                            r_cnt   <= EGAP_M1;
                        end else begin
                            r_state <= S_LETTER_GAP;
                            r_cnt   <= LGAP_M1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_ELEM_GAP: begin
                    if (w_cnt_done) begin
                        r_state <= S_MARK;
                        r_cnt   <= r_shift[4] ? DASH_M1 : DOT_M1;
                        r_shift <= {r_shift[3:0], 1'b0};
                        r_elems <= r_elems - 3'd1;
                        r_key   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_LETTER_GAP, S_WORD_GAP: begin
                    if (w_cnt_done) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_key   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign key_o  = r_key;
    assign busy_o = r_busy;
    assign err_o  = r_err;

endmodule
